// File: rtl/multi_lane_field_iter_pkg.sv
// Shared types for the Game of Life generation sequencer: field select, FSM states,
// neighbourhood size and the address-width helper.
package multi_lane_field_iter_pkg;

   typedef enum logic {
      FIELD_A = 1'b0,
      FIELD_B = 1'b1
   } cur_field_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } iter_state_t;

   localparam int NEIGHBOURS_CNT = 8;

   // A one-entry dimension still needs a 1-bit address.
   function automatic int adr_size(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic cur_field_t other_field(input cur_field_t f);
      return (f == FIELD_A) ? FIELD_B : FIELD_A;
   endfunction

endpackage

// File: rtl/multi_lane_field_iter_next_cell_state.sv
// Life rule for one cell: born with exactly 3 live neighbours, survives with 2 or 3.
// Purely combinational.
module multi_lane_field_iter_next_cell_state
   import multi_lane_field_iter_pkg::*;
(
   input  logic                      cell_i,
   input  logic [NEIGHBOURS_CNT-1:0] nbrs_i,
   output logic                      new_cell_o
);

   logic [3:0] live_cnt;

   always_comb begin
      live_cnt = '0;
      for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
         live_cnt = live_cnt + {3'b000, nbrs_i[i]};
      end
      new_cell_o = (live_cnt == 4'd3) || (cell_i && (live_cnt == 4'd2));
   end

endmodule

// File: rtl/multi_lane_field_iter.sv
// Raster-order generation sequencer, LANES cells per cycle; write-back lags the fetch address by one cycle.
// Run/step modes, stop at generation boundary, generation counter, gap-free back-to-back generations.
module multi_lane_field_iter
   import multi_lane_field_iter_pkg::*;
#(
   parameter int FIELD_W = 16,
   parameter int FIELD_H = 16,
   parameter int LANES   = 1,
   parameter int GEN_W   = 16,
   localparam int X_ADR_SIZE = adr_size(FIELD_W),
   localparam int Y_ADR_SIZE = adr_size(FIELD_H)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_go,
   input  logic                              i_run,
   input  logic                              i_stop,
   input  logic [LANES-1:0]                  i_next_cells,
   input  logic [NEIGHBOURS_CNT*LANES-1:0]   i_next_nbrs,
   output logic                              o_busy,
   output logic [X_ADR_SIZE-1:0]             o_cur_x,
   output logic [Y_ADR_SIZE-1:0]             o_cur_y,
   output logic [X_ADR_SIZE-1:0]             o_next_x,
   output logic [Y_ADR_SIZE-1:0]             o_next_y,
   output cur_field_t                        o_next_read_field,
   output cur_field_t                        o_read_field,
   output logic                              o_wr_en,
   output logic [LANES-1:0]                  o_new_cells,
   output logic [GEN_W-1:0]                  o_gen_cnt,
   output logic                              o_gen_done
);

   if (LANES < 1) begin : g_bad_lanes
      $error("multi_lane_field_iter: LANES must be at least 1");
   end else if (FIELD_W % LANES != 0) begin : g_bad_width
      $error("multi_lane_field_iter: FIELD_W must be a multiple of LANES");
   end

   localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES);
   localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - LANES);
   localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

   typedef struct packed {
      iter_state_t                       st;
      logic [X_ADR_SIZE-1:0]             x;
      logic [Y_ADR_SIZE-1:0]             y;
      cur_field_t                        field;
      logic [GEN_W-1:0]                  gen;
      logic                              done;
      logic                              stop;
      logic [LANES-1:0]                  cells;
      logic [NEIGHBOURS_CNT*LANES-1:0]   nbrs;
   } iter_regs_t;

   iter_regs_t state_q;
   iter_regs_t state_d;
   logic       last_x;
   logic       last_y;

   always_comb begin
      state_d       = state_q;
      state_d.done  = 1'b0;
      state_d.cells = i_next_cells;
      state_d.nbrs  = i_next_nbrs;
      last_x        = (state_q.x == X_LAST);
      last_y        = (state_q.y == Y_LAST);
      case (state_q.st)
         IDLE: begin
            state_d.x    = '0;
            state_d.y    = '0;
            state_d.stop = 1'b0;
            if ((i_go || i_run) && !i_stop) begin
               state_d.st = SCAN;
            end
         end
         SCAN: begin
            state_d.stop = state_q.stop | i_stop;
            if (!last_x) begin
               state_d.x = state_q.x + X_STEP;
            end else begin
               state_d.x = '0;
               if (!last_y) begin
                  state_d.y = state_q.y + Y_ADR_SIZE'(1);
               end else begin
                  // Flipping the field here makes the (0,0) fetch already target the fresh field.
                  state_d.y     = '0;
                  state_d.field = other_field(state_q.field);
                  state_d.gen   = state_q.gen + GEN_W'(1);
                  state_d.done  = 1'b1;
                  if (!(i_run && !state_d.stop)) begin
                     state_d.st   = IDLE;
                     state_d.stop = 1'b0;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q.st    <= IDLE;
         state_q.x     <= '0;
         state_q.y     <= '0;
         state_q.field <= FIELD_A;
         state_q.gen   <= '0;
         state_q.done  <= 1'b0;
         state_q.stop  <= 1'b0;
         state_q.cells <= '0;
         state_q.nbrs  <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      multi_lane_field_iter_next_cell_state u_next_cell_state (
         .cell_i     (state_q.cells[k]),
         .nbrs_i     (state_q.nbrs[NEIGHBOURS_CNT*k +: NEIGHBOURS_CNT]),
         .new_cell_o (o_new_cells[k])
      );
   end

   assign o_busy            = (state_q.st == SCAN);
   assign o_wr_en           = (state_q.st == SCAN);
   assign o_cur_x           = state_q.x;
   assign o_cur_y           = state_q.y;
   assign o_next_x          = state_d.x;
   assign o_next_y          = state_d.y;
   assign o_next_read_field = state_d.field;
   assign o_read_field      = state_q.field;
   assign o_gen_cnt         = state_q.gen;
   assign o_gen_done        = state_q.done;

endmodule

// File: tb/tb_multi_lane_field_iter.sv
// Three sequencer instances (4x4/1 lane/2-bit gen, 8x2/4 lanes, 5x5/1 lane) around behavioural
// double-buffered field memories, checked against a golden Life model through a write scoreboard.
module tb_multi_lane_field_iter;
   import multi_lane_field_iter_pkg::*;

   localparam int ND = 3;

   function automatic int cfg_w(input int g);
      return (g == 0) ? 4 : (g == 1) ? 8 : 5;
   endfunction
   function automatic int cfg_h(input int g);
      return (g == 0) ? 4 : (g == 1) ? 2 : 5;
   endfunction
   function automatic int cfg_l(input int g);
      return (g == 1) ? 4 : 1;
   endfunction
   function automatic int cfg_g(input int g);
      return (g == 0) ? 2 : 16;
   endfunction

   typedef struct {
      int         x;
      int         y;
      logic [3:0] cells;
   } wr_t;

   typedef struct {
      int         g;
      logic       go;
      logic       run;
      logic       stop;
      int         gens;
      int         exp_gen;
      cur_field_t exp_rf;
   } row_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       t_rst [ND];
   logic       t_go  [ND];
   logic       t_run [ND];
   logic       t_stop[ND];
   logic       m_busy[ND];
   logic       m_wr  [ND];
   logic       m_done[ND];
   cur_field_t m_rf  [ND];
   cur_field_t m_nrf [ND];
   int         m_cx  [ND];
   int         m_cy  [ND];
   int         m_nx  [ND];
   int         m_ny  [ND];
   int         m_gen [ND];
   logic [3:0] m_cells[ND];

   logic fld [ND][2][8][8];
   logic gold[ND][8][8];
   wr_t  sbq [ND][$];
   int   wr_cnt   [ND];
   logic pend_done[ND];
   int   n_vec = 0;
   int   n_bad = 0;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int W  = cfg_w(g);
      localparam int H  = cfg_h(g);
      localparam int L  = cfg_l(g);
      localparam int GW = cfg_g(g);
      localparam int XS = adr_size(W);
      localparam int YS = adr_size(H);

      logic            busy, wr_en, done;
      logic [XS-1:0]   cx, nx;
      logic [YS-1:0]   cy, ny;
      cur_field_t      rf, nrf;
      logic [L-1:0]    cells_in, new_cells;
      logic [8*L-1:0]  nbrs_in;
      logic [GW-1:0]   gen;

      multi_lane_field_iter #(.FIELD_W(W), .FIELD_H(H), .LANES(L), .GEN_W(GW)) u_dut (
         .clk               (clk),
         .rst               (t_rst[g]),
         .i_go              (t_go[g]),
         .i_run             (t_run[g]),
         .i_stop            (t_stop[g]),
         .i_next_cells      (cells_in),
         .i_next_nbrs       (nbrs_in),
         .o_busy            (busy),
         .o_cur_x           (cx),
         .o_cur_y           (cy),
         .o_next_x          (nx),
         .o_next_y          (ny),
         .o_next_read_field (nrf),
         .o_read_field      (rf),
         .o_wr_en           (wr_en),
         .o_new_cells       (new_cells),
         .o_gen_cnt         (gen),
         .o_gen_done        (done)
      );

      assign m_busy[g]  = busy;
      assign m_wr[g]    = wr_en;
      assign m_done[g]  = done;
      assign m_rf[g]    = rf;
      assign m_nrf[g]   = nrf;
      assign m_cx[g]    = int'(cx);
      assign m_cy[g]    = int'(cy);
      assign m_nx[g]    = int'(nx);
      assign m_ny[g]    = int'(ny);
      assign m_gen[g]   = int'(gen);
      assign m_cells[g] = 4'(new_cells);

      // Field memory read port: zero outside the field.
      always_comb begin
         int xx, yy, n, bx;
         xx = 0; yy = 0; n = 0; bx = 0;
         cells_in = '0;
         nbrs_in  = '0;
         for (int k = 0; k < L; k++) begin
            bx = int'(nx) + k;
            cells_in[k] = fld[g][int'(nrf)][int'(ny)][bx];
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  if (dy != 0 || dx != 0) begin
                     yy = int'(ny) + dy;
                     xx = bx + dx;
                     nbrs_in[8*k+n] = (yy >= 0 && yy < H && xx >= 0 && xx < W) ?
                                      fld[g][int'(nrf)][yy][xx] : 1'b0;
                     n++;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic gold_at(input int g, input int y, input int x);
      if (y < 0 || y >= cfg_h(g) || x < 0 || x >= cfg_w(g)) return 1'b0;
      return gold[g][y][x];
   endfunction

   function automatic logic blink(input logic horiz, input int x, input int y);
      return horiz ? (y == 2 && x >= 1 && x <= 3) : (x == 2 && y >= 1 && y <= 3);
   endfunction

   // Expected writes of one generation, raster order, one entry per lane group.
   task automatic push_gen(input int g);
      logic nxt[8][8];
      int   c;
      wr_t  e;
      for (int y = 0; y < cfg_h(g); y++) begin
         for (int x = 0; x < cfg_w(g); x++) begin
            c = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (dy != 0 || dx != 0) c += int'(gold_at(g, y + dy, x + dx));
            nxt[y][x] = (c == 3) || (gold[g][y][x] && c == 2);
         end
      end
      for (int y = 0; y < cfg_h(g); y++) begin
         for (int x = 0; x < cfg_w(g); x += cfg_l(g)) begin
            e.x = x; e.y = y; e.cells = '0;
            for (int k = 0; k < cfg_l(g); k++) e.cells[k] = nxt[y][x+k];
            sbq[g].push_back(e);
         end
      end
      for (int y = 0; y < cfg_h(g); y++)
         for (int x = 0; x < cfg_w(g); x++) gold[g][y][x] = nxt[y][x];
   endtask

   // One clock; outputs are sampled and the memory written on the falling edge.
   task automatic tick();
      wr_t  e;
      logic last;
      int   wf;
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
         check($sformatf("gen_done[%0d]", g), int'(m_done[g]), int'(pend_done[g] && !t_rst[g]));
         pend_done[g] = 1'b0;
         if (m_wr[g]) begin
            last = (m_cx[g] == cfg_w(g) - cfg_l(g)) && (m_cy[g] == cfg_h(g) - 1);
            check($sformatf("next_field_flip[%0d]", g), int'(m_nrf[g] != m_rf[g]), int'(last));
            if (sbq[g].size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL unexpected_write[%0d]: got write at x=%0d y=%0d, expected none",
                        g, m_cx[g], m_cy[g]);
            end else begin
               e = sbq[g].pop_front();
               check($sformatf("wr_x[%0d]", g), m_cx[g], e.x);
               check($sformatf("wr_y[%0d]", g), m_cy[g], e.y);
               check($sformatf("wr_cells[%0d]", g), int'(m_cells[g]), int'(e.cells));
            end
            wf = (m_rf[g] == FIELD_A) ? 1 : 0;
            for (int k = 0; k < cfg_l(g); k++)
               if (m_cy[g] < 8 && m_cx[g] + k < 8) fld[g][wf][m_cy[g]][m_cx[g]+k] = m_cells[g][k];
            wr_cnt[g]++;
            pend_done[g] = last;
         end
      end
   endtask

   task automatic wait_idle(input int g);
      int cyc = 0;
      while (m_busy[g] && cyc < 500) begin
         tick();
         cyc++;
      end
      if (m_busy[g]) begin
         n_vec++; n_bad++;
         $display("FAIL idle_timeout[%0d]: got busy after %0d cycles, expected idle", g, cyc);
      end
   endtask

   task automatic run_row(input row_t r);
      int         g      = r.g;
      int         groups = cfg_w(r.g) / cfg_l(r.g) * cfg_h(r.g);
      int         wc0    = wr_cnt[r.g];
      int         cyc    = 0;
      int         ndone  = 0;
      int         first  = -1;
      int         lastc  = -1;
      cur_field_t rfp    = m_rf[r.g];
      for (int i = 0; i < r.gens; i++) push_gen(g);
      t_go[g] = r.go; t_run[g] = r.run; t_stop[g] = r.stop;
      do begin
         tick();
         t_go[g] = 1'b0; t_stop[g] = 1'b0;
         if (m_wr[g]) begin
            if (first < 0) first = cyc;
            lastc = cyc;
         end
         if (m_done[g]) begin
            ndone++;
            check($sformatf("field_flip[%0d]", g), int'(m_rf[g] != rfp), 1);
            rfp = m_rf[g];
         end
         if (ndone >= r.gens - 1) t_run[g] = 1'b0;
         cyc++;
      end while (m_busy[g] && cyc < 400);
      t_run[g] = 1'b0;
      if (m_busy[g]) begin
         n_vec++; n_bad++;
         $display("FAIL row_timeout[%0d]: got busy after %0d cycles, expected idle", g, cyc);
      end
      check($sformatf("row_writes[%0d]", g), wr_cnt[g] - wc0, r.gens * groups);
      if (r.gens > 0) check($sformatf("row_no_gap[%0d]", g), lastc - first + 1, r.gens * groups);
      check($sformatf("row_gen_done[%0d]", g), ndone, r.gens);
      check($sformatf("row_gen_cnt[%0d]", g), m_gen[g], r.exp_gen);
      check($sformatf("row_read_field[%0d]", g), int'(m_rf[g]), int'(r.exp_rf));
      check($sformatf("row_sb_empty[%0d]", g), sbq[g].size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      row_t rows[5];
      int   wc0, cyc, mism;

      rows[0] = '{0, 1'b1, 1'b0, 1'b0, 1, 1, FIELD_B};   // single step
      rows[1] = '{0, 1'b1, 1'b0, 1'b1, 0, 1, FIELD_B};   // stop in IDLE blocks go
      rows[2] = '{0, 1'b0, 1'b1, 1'b0, 3, 0, FIELD_A};   // run 3 gens, 2-bit counter wraps to 0
      rows[3] = '{1, 1'b1, 1'b0, 1'b0, 1, 1, FIELD_B};   // 4 lanes
      rows[4] = '{1, 1'b0, 1'b1, 1'b0, 2, 3, FIELD_B};

      for (int g = 0; g < ND; g++) begin
         t_rst[g] = 1'b1; t_go[g] = 1'b0; t_run[g] = 1'b0; t_stop[g] = 1'b0;
         wr_cnt[g] = 0; pend_done[g] = 1'b0;
         for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
               fld[g][1][y][x] = 1'b0;
               if (g == 2) fld[g][0][y][x] = blink(1'b0, x, y);
               else        fld[g][0][y][x] = (y < cfg_h(g) && x < cfg_w(g)) ? 1'($urandom_range(1)) : 1'b0;
               gold[g][y][x] = fld[g][0][y][x];
            end
      end

      tick();
      tick();
      for (int g = 0; g < ND; g++) begin
         check($sformatf("rst_busy[%0d]", g), int'(m_busy[g]), 0);
         check($sformatf("rst_wr_en[%0d]", g), int'(m_wr[g]), 0);
         check($sformatf("rst_read_field[%0d]", g), int'(m_rf[g]), int'(FIELD_A));
         check($sformatf("rst_gen_cnt[%0d]", g), m_gen[g], 0);
         check($sformatf("rst_cur_xy[%0d]", g), m_cx[g] + m_cy[g], 0);
         check($sformatf("rst_next_xy[%0d]", g), m_nx[g] + m_ny[g], 0);
         t_rst[g] = 1'b0;
      end
      tick();

      for (int i = 0; i < 5; i++) run_row(rows[i]);

      // Stop requested mid-generation in run mode: the generation still completes.
      push_gen(0);
      wc0 = wr_cnt[0]; cyc = 0;
      t_run[0] = 1'b1;
      do begin
         tick();
         t_stop[0] = (wr_cnt[0] - wc0 == 5);
         cyc++;
      end while ((m_busy[0] || cyc < 2) && cyc < 100);
      t_run[0] = 1'b0; t_stop[0] = 1'b0;
      check("stop_writes", wr_cnt[0] - wc0, 16);
      check("stop_busy", int'(m_busy[0]), 0);
      check("stop_gen_cnt", m_gen[0], 1);
      check("stop_read_field", int'(m_rf[0]), int'(FIELD_B));
      tick();
      check("stop_stays_idle", int'(m_busy[0]), 0);

      // Reset in the middle of a scan.
      push_gen(0);
      wc0 = wr_cnt[0]; cyc = 0;
      t_go[0] = 1'b1;
      tick();
      t_go[0] = 1'b0;
      while (wr_cnt[0] - wc0 < 7 && cyc < 50) begin
         tick();
         cyc++;
      end
      t_rst[0] = 1'b1;
      tick();
      check("mid_rst_wr_en", int'(m_wr[0]), 0);
      check("mid_rst_busy", int'(m_busy[0]), 0);
      check("mid_rst_read_field", int'(m_rf[0]), int'(FIELD_A));
      check("mid_rst_gen_cnt", m_gen[0], 0);
      t_rst[0] = 1'b0;
      sbq[0].delete();
      wc0 = wr_cnt[0];
      tick();
      check("post_rst_no_write", wr_cnt[0] - wc0, 0);

      // Blinker, with a go pulse dropped while busy.
      push_gen(2);
      wc0 = wr_cnt[2];
      t_go[2] = 1'b1;
      tick();
      t_go[2] = 1'b0;
      repeat (5) tick();
      t_go[2] = 1'b1;
      tick();
      t_go[2] = 1'b0;
      wait_idle(2);
      tick();
      check("blink1_writes", wr_cnt[2] - wc0, 25);
      check("blink1_gen_cnt", m_gen[2], 1);
      check("blink1_busy", int'(m_busy[2]), 0);
      mism = 0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) mism += int'(fld[2][1][y][x] != blink(1'b1, x, y));
      check("blink1_pattern", mism, 0);

      push_gen(2);
      wc0 = wr_cnt[2];
      t_go[2] = 1'b1;
      tick();
      t_go[2] = 1'b0;
      wait_idle(2);
      check("blink2_writes", wr_cnt[2] - wc0, 25);
      check("blink2_gen_cnt", m_gen[2], 2);
      check("blink2_read_field", int'(m_rf[2]), int'(FIELD_A));
      mism = 0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) mism += int'(fld[2][0][y][x] != blink(1'b0, x, y));
      check("blink2_pattern", mism, 0);
      check("blink_sb_empty", sbq[2].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
